thermostat_zone_ctrl: RTL and testbench
=======================================

Name: thermostat_zone_ctrl

Overview:
- Multi-zone HVAC thermostat controller; NZONES independent per-zone FSMs.
- Each zone drives heater, aircon and fan from mode, too_cold, too_hot and fan_on.
- Adds equipment protection: minimum run time, post-run fan purge, minimum off-time lockout.
- Sits between per-zone sensor/threshold logic and the relay driver bank.

Parameters:
- NZONES, 4: number of independent zones; must be >= 1.
- MIN_ON, 8: minimum cycles heater/aircon stays asserted once started; must be >= 1.
- PURGE, 3: cycles the fan is forced on after heater/aircon drops; must be >= 1.
- MIN_OFF, 4: lockout cycles after purge before a zone may restart; must be >= 1.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- mode  input  NZONES  per zone: 1 = heat mode, 0 = cool mode
- too_cold  input  NZONES  per-zone cold demand
- too_hot  input  NZONES  per-zone hot demand
- fan_on  input  NZONES  per-zone user fan request
- heater  output  NZONES  per-zone heater enable
- aircon  output  NZONES  per-zone air-conditioner enable
- fan  output  NZONES  per-zone fan enable

Behaviour:
- Per zone z: state register (IDLE, HEAT, COOL, PURGE, LOCKOUT) and down-counter. The counter is sized to clog2(max(MIN_ON, PURGE, MIN_OFF)).
- Zones are fully independent; there is no shared arbitration.
- Reset (reset_n low, asynchronous): every zone goes to IDLE and its counter to 0. heater = aircon = 0 immediately. fan = fan_on.
- Reset asserted mid-operation aborts any HEAT/COOL/PURGE/LOCKOUT at once. No purge occurs on reset.
- Outputs: heater = (state==HEAT); aircon = (state==COOL).
  - These are Moore outputs, one cycle of latency from the sampled demand.
- fan = heater | aircon | (state==PURGE) | fan_on[z].
  - The fan_on term is a combinational pass-through.
- IDLE:
  - mode & too_cold -> HEAT, counter loaded with MIN_ON-1.
  - else ~mode & too_hot -> COOL, counter loaded with MIN_ON-1.
  - else stay in IDLE.
  - Demand not matching mode is ignored. If too_cold and too_hot are both high, only the mode-consistent one is used.
- HEAT:
  - Counter decrements each cycle while nonzero.
  - When counter==0 and !(mode & too_cold) -> PURGE, counter loaded with PURGE-1. Otherwise stay in HEAT.
  - A mode flip or demand drop before MIN_ON expires is ignored until the counter reaches 0.
- COOL: same as HEAT, using the condition ~mode & too_hot.
- Minimum run: heater/aircon is high for exactly MIN_ON cycles if demand drops immediately after entry. It stays high for longer while demand persists.
- PURGE:
  - Counter decrements each cycle.
  - At counter==0 -> LOCKOUT, counter loaded with MIN_OFF-1.
  - Demand is ignored in this state.
- LOCKOUT:
  - Counter decrements each cycle.
  - At counter==0 -> IDLE.
  - Demand is ignored; heater = aircon = 0.
- Restart: the earliest restart is the cycle after IDLE is re-entered, since IDLE itself costs one cycle.
- Counters never wrap. A zone never holds heater and aircon high at the same time.

Optional Feature:
- Macro: THERMOSTAT_ZONE_CTRL_STATUS_EN.
- When defined: adds output active_count, width clog2(NZONES+1).
  - It is a registered count of zones in HEAT or COOL, updated every cycle from the next-state values, so it matches the heater/aircon outputs in the same cycle.
  - Reset value: 0.
- When undefined: no active_count port; behaviour is otherwise identical.

Test Plan:
All scenarios use NZONES=4, MIN_ON=8, PURGE=3, MIN_OFF=4.
- Reset: hold reset_n=0 with fan_on=4'b0101 and all demand high -> heater=0, aircon=0, fan=4'b0101. Release -> first HEAT/COOL output appears one cycle after the first sampling edge.
- Zone 0 minimum run: mode[0]=1, too_cold[0] pulsed for 1 cycle -> heater[0] high exactly 8 cycles, then fan[0] alone for 3 cycles, then 4 lockout cycles with all outputs 0; a new demand pulse during lockout is ignored.
- Zone 1 sustained cool: mode[1]=0, too_hot[1] held 20 cycles -> aircon[1] high 20 cycles, then 3 purge cycles. A mode[1] flip to 1 at cycle 3 of COOL leaves aircon[1] high through cycle 8, then it drops.
- Conflicting demand: mode[2]=1, too_cold[2]=too_hot[2]=1 -> heater[2]=1, aircon[2]=0 throughout.
- Zone independence: stagger demand on all 4 zones by 2 cycles -> each zone follows its own 8/3/4 timeline. With the status macro defined, active_count peaks at 4.
- Async reset mid-HEAT at cycle 5 -> heater drops immediately, no purge; after release the zone is IDLE and restarts on demand.

Source files
------------

// File: rtl/thermostat_zone_ctrl_if.sv
// Demand/relay bundle between the zone sensor logic (master) and the
// thermostat controller (slave); one bit per zone on every signal.
interface thermostat_zone_ctrl_if #(
    parameter int NZONES = 4
);
    logic [NZONES-1:0] mode;
    logic [NZONES-1:0] too_cold;
    logic [NZONES-1:0] too_hot;
    logic [NZONES-1:0] fan_on;
    logic [NZONES-1:0] heater;
    logic [NZONES-1:0] aircon;
    logic [NZONES-1:0] fan;

    modport master (
        output mode, too_cold, too_hot, fan_on,
        input  heater, aircon, fan
    );

    modport slave (
        input  mode, too_cold, too_hot, fan_on,
        output heater, aircon, fan
    );
endinterface

// File: rtl/thermostat_zone_ctrl.sv
// Multi-zone HVAC controller with minimum run, fan purge and off-time lockout.
// Optional macro THERMOSTAT_ZONE_CTRL_STATUS_EN adds the active_count output.
module thermostat_zone_ctrl #(
    parameter int NZONES  = 4,
    parameter int MIN_ON  = 8,
    parameter int PURGE   = 3,
    parameter int MIN_OFF = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    thermostat_zone_ctrl_if.slave        zif
`ifdef THERMOSTAT_ZONE_CTRL_STATUS_EN
    ,
    output logic [$clog2(NZONES+1)-1:0]  active_count
`endif
);

    localparam int MAX_A = (MIN_ON > PURGE) ? MIN_ON : PURGE;
    localparam int MAX_T = (MAX_A > MIN_OFF) ? MAX_A : MIN_OFF;
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CW-1:0] ON_LD    = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] PURGE_LD = CW'(PURGE - 1);
    localparam logic [CW-1:0] OFF_LD   = CW'(MIN_OFF - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAT,
        S_COOL,
        S_PURGE,
        S_LOCKOUT
    } state_e;

    state_e          state_q [NZONES];
    state_e          state_d [NZONES];
    logic [CW-1:0]   cnt_q   [NZONES];
    logic [CW-1:0]   cnt_d   [NZONES];

    logic [NZONES-1:0] heat_dem;
    logic [NZONES-1:0] cool_dem;
    logic [NZONES-1:0] heater_o;
    logic [NZONES-1:0] aircon_o;
    logic [NZONES-1:0] purge_o;

    // Only demand consistent with the zone's mode counts.
    assign heat_dem =  zif.mode & zif.too_cold;
    assign cool_dem = ~zif.mode & zif.too_hot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int z = 0; z < NZONES; z++) begin
                state_q[z] <= S_IDLE;
                cnt_q[z]   <= '0;
            end
        end else begin
            for (int z = 0; z < NZONES; z++) begin
                state_q[z] <= state_d[z];
                cnt_q[z]   <= cnt_d[z];
            end
        end
    end

    always_comb begin
        for (int z = 0; z < NZONES; z++) begin
            state_d[z] = state_q[z];
            cnt_d[z]   = cnt_q[z];
            unique case (state_q[z])
                S_IDLE: begin
                    if (heat_dem[z]) begin
                        state_d[z] = S_HEAT;
                        cnt_d[z]   = ON_LD;
                    end else if (cool_dem[z]) begin
                        state_d[z] = S_COOL;
                        cnt_d[z]   = ON_LD;
                    end
                end
                S_HEAT: begin
                    if (cnt_q[z] != '0) begin
                        cnt_d[z] = cnt_q[z] - ONE;
                    end else if (!heat_dem[z]) begin
                        state_d[z] = S_PURGE;
                        cnt_d[z]   = PURGE_LD;
                    end
                end
                S_COOL: begin
                    if (cnt_q[z] != '0) begin
                        cnt_d[z] = cnt_q[z] - ONE;
                    end else if (!cool_dem[z]) begin
                        state_d[z] = S_PURGE;
                        cnt_d[z]   = PURGE_LD;
                    end
                end
                S_PURGE: begin
                    if (cnt_q[z] != '0) begin
                        cnt_d[z] = cnt_q[z] - ONE;
                    end else begin
                        state_d[z] = S_LOCKOUT;
                        cnt_d[z]   = OFF_LD;
                    end
                end
                S_LOCKOUT: begin
                    if (cnt_q[z] != '0) begin
                        cnt_d[z] = cnt_q[z] - ONE;
                    end else begin
                        state_d[z] = S_IDLE;
                    end
                end
                default: begin
                    state_d[z] = S_IDLE;
                    cnt_d[z]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        heater_o = '0;
        aircon_o = '0;
        purge_o  = '0;
        for (int z = 0; z < NZONES; z++) begin
            heater_o[z] = (state_q[z] == S_HEAT);
            aircon_o[z] = (state_q[z] == S_COOL);
            purge_o[z]  = (state_q[z] == S_PURGE);
        end
    end

    // The user fan request bypasses the state so it also holds during reset.
    assign zif.heater = heater_o;
    assign zif.aircon = aircon_o;
    assign zif.fan    = heater_o | aircon_o | purge_o | zif.fan_on;

`ifdef THERMOSTAT_ZONE_CTRL_STATUS_EN
    localparam int ACW = $clog2(NZONES + 1);

    logic [ACW-1:0] active_count_q;
    logic [ACW-1:0] active_count_d;

    // Counted from next-state so the register lines up with heater/aircon.
    always_comb begin
        active_count_d = '0;
        for (int z = 0; z < NZONES; z++) begin
            if ((state_d[z] == S_HEAT) || (state_d[z] == S_COOL)) begin
                active_count_d = active_count_d + ACW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_count_q <= '0;
        end else begin
            active_count_q <= active_count_d;
        end
    end

    assign active_count = active_count_q;
`endif

endmodule

// File: tb/tb_thermostat_zone_ctrl.sv
// Randomised and directed bench for thermostat_zone_ctrl against a
// timestamp-based reference model of run, purge and lockout windows.
module tb_thermostat_zone_ctrl;

    localparam int NZ      = 4;
    localparam int MIN_ON  = 8;
    localparam int PURGE   = 3;
    localparam int MIN_OFF = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    thermostat_zone_ctrl_if #(.NZONES(NZ)) zif ();

`ifdef THERMOSTAT_ZONE_CTRL_STATUS_EN
    logic [2:0] active_count;
`endif

    thermostat_zone_ctrl #(
        .NZONES  (NZ),
        .MIN_ON  (MIN_ON),
        .PURGE   (PURGE),
        .MIN_OFF (MIN_OFF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .zif     (zif)
`ifdef THERMOSTAT_ZONE_CTRL_STATUS_EN
        ,
        .active_count (active_count)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: each zone is either running (kind 1 heat / 2 cool, started at
    // edge start_n) or off since edge stop_n; purge, lockout and idle are
    // just windows of elapsed edges since the stop.
    int cyc;
    int kind    [NZ];
    int start_n [NZ];
    int stop_n  [NZ];

    function automatic bit wants(input int k, input int z);
        if (k == 1) return zif.mode[z] && zif.too_cold[z];
        return !zif.mode[z] && zif.too_hot[z];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= 0;
            for (int z = 0; z < NZ; z++) begin
                kind[z]    <= 0;
                start_n[z] <= 0;
                stop_n[z]  <= -100;
            end
        end else begin
            cyc <= cyc + 1;
            for (int z = 0; z < NZ; z++) begin
                if (kind[z] != 0) begin
                    if ((cyc - start_n[z] >= MIN_ON) && !wants(kind[z], z)) begin
                        kind[z]   <= 0;
                        stop_n[z] <= cyc;
                    end
                end else if (cyc - 1 - stop_n[z] >= PURGE + MIN_OFF) begin
                    if (zif.mode[z] && zif.too_cold[z]) begin
                        kind[z]    <= 1;
                        start_n[z] <= cyc;
                    end else if (!zif.mode[z] && zif.too_hot[z]) begin
                        kind[z]    <= 2;
                        start_n[z] <= cyc;
                    end
                end
            end
        end
    end

    function automatic logic [NZ-1:0] exp_heater();
        logic [NZ-1:0] r = '0;
        for (int z = 0; z < NZ; z++) r[z] = (kind[z] == 1);
        return r;
    endfunction

    function automatic logic [NZ-1:0] exp_aircon();
        logic [NZ-1:0] r = '0;
        for (int z = 0; z < NZ; z++) r[z] = (kind[z] == 2);
        return r;
    endfunction

    function automatic logic [NZ-1:0] exp_fan();
        logic [NZ-1:0] r = '0;
        for (int z = 0; z < NZ; z++) begin
            r[z] = (kind[z] != 0) || ((cyc - 1 - stop_n[z]) < PURGE) || zif.fan_on[z];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("heater", int'(zif.heater), int'(exp_heater()));
            check_output("aircon", int'(zif.aircon), int'(exp_aircon()));
            check_output("fan",    int'(zif.fan),    int'(exp_fan()));
`ifdef THERMOSTAT_ZONE_CTRL_STATUS_EN
            check_output("active_count", int'(active_count),
                         $countones(exp_heater() | exp_aircon()));
`endif
        end
    end

    logic [31:0] hrec;
    logic [31:0] arec;
    logic [31:0] frec;
    int          peak;
    logic [NZ-1:0] dmask;

    task automatic drain();
        @(posedge clk);
        #1;
        zif.mode     = '0;
        zif.too_cold = '0;
        zif.too_hot  = '0;
        zif.fan_on   = '0;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        reset_n      = 1'b1;
        zif.mode     = 4'b0011;
        zif.too_cold = 4'b1111;
        zif.too_hot  = 4'b1111;
        zif.fan_on   = 4'b0101;
        #1 reset_n   = 1'b0;
        cmp_en       = 1'b1;

        // Reset holds relays off while the user fan passes through.
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_heater", int'(zif.heater), 0);
        check_output("rst_aircon", int'(zif.aircon), 0);
        check_output("rst_fan",    int'(zif.fan),    5);
        @(negedge clk) reset_n = 1'b1;
        #1 check_output("rel_heater_before_edge", int'(zif.heater), 0);
        @(negedge clk);
        check_output("rel_heater_first", int'(zif.heater), 3);
        check_output("rel_aircon_first", int'(zif.aircon), 12);
        drain();

        // Zone 0 single-cycle pulse; a second pulse lands in lockout.
        hrec = '0;
        frec = '0;
        @(posedge clk);
        #1;
        zif.mode     = 4'b0001;
        zif.too_cold = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 0)  zif.too_cold = 4'b0000;
            if (i == 12) zif.too_cold = 4'b0001;
            if (i == 13) zif.too_cold = 4'b0000;
            @(negedge clk);
            hrec[i] = zif.heater[0];
            frec[i] = zif.fan[0];
        end
        check_output("z0_heater_pattern", int'(hrec[15:0]), 32'h00FF);
        check_output("z0_fan_pattern",    int'(frec[15:0]), 32'h07FF);
        drain();

        // Zone 1 cool demand held for 20 sampling edges.
        arec = '0;
        frec = '0;
        @(posedge clk);
        #1;
        zif.too_hot = 4'b0010;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 19) zif.too_hot = 4'b0000;
            @(negedge clk);
            arec[i] = zif.aircon[1];
            frec[i] = zif.fan[1] & ~zif.aircon[1];
        end
        check_output("z1_hold_on_cycles", $countones(arec), 20);
        check_output("z1_hold_last_on",   int'(arec[19]), 1);
        check_output("z1_purge_cycles",   $countones(frec), 3);
        drain();

        // Mode flip during the minimum run is ignored until it expires.
        arec = '0;
        @(posedge clk);
        #1;
        zif.too_hot = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) zif.mode = 4'b0010;
            @(negedge clk);
            arec[i] = zif.aircon[1];
        end
        check_output("z1_flip_pattern", int'(arec[11:0]), 32'h00FF);
        drain();

        // Both demands high in heat mode: heater only.
        hrec = '0;
        arec = '0;
        @(posedge clk);
        #1;
        zif.mode     = 4'b0100;
        zif.too_cold = 4'b0100;
        zif.too_hot  = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            hrec[i] = zif.heater[2];
            arec[i] = zif.aircon[2];
        end
        check_output("z2_conflict_heater", $countones(hrec), 12);
        check_output("z2_conflict_aircon", $countones(arec), 0);
        drain();

        // Staggered pulses two cycles apart overlap on all four zones.
        peak = 0;
        zif.mode = 4'b0101;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk);
            #1;
            dmask = '0;
            if ((j % 2 == 0) && (j < 8)) dmask = 4'b0001 << (j / 2);
            zif.too_cold = dmask & zif.mode;
            zif.too_hot  = dmask & ~zif.mode;
            @(negedge clk);
            if ($countones(zif.heater | zif.aircon) > peak) peak = $countones(zif.heater | zif.aircon);
`ifdef THERMOSTAT_ZONE_CTRL_STATUS_EN
            if (int'(active_count) > peak) peak = int'(active_count);
`endif
        end
        check_output("stagger_peak", peak, 4);
        drain();

        // Asynchronous reset in the fifth heater cycle: no purge afterwards.
        @(posedge clk);
        #1;
        zif.mode     = 4'b0001;
        zif.too_cold = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output("mid_heat_before_reset", int'(zif.heater[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        check_output("mid_reset_heater", int'(zif.heater[0]), 0);
        check_output("mid_reset_fan",    int'(zif.fan[0]),    0);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1 check_output("post_reset_idle", int'(zif.fan[0]), 0);
        @(negedge clk);
        check_output("post_reset_restart", int'(zif.heater[0]), 1);
        drain();

        // Random traffic with occasional asynchronous resets.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(15) == 0) zif.mode = zif.mode ^ (4'b0001 << $urandom_range(3));
            zif.too_cold = zif.too_cold ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            zif.too_hot  = zif.too_hot  ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            zif.fan_on   = 4'($urandom_range(15));
            if ($urandom_range(399) == 0) begin
                @(negedge clk);
                #1 reset_n = 1'b0;
                #1;
                check_output("rand_reset_relays", int'(zif.heater | zif.aircon), 0);
                check_output("rand_reset_fan",    int'(zif.fan), int'(zif.fan_on));
                #1 reset_n = 1'b1;
            end
        end

        @(posedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
